// File: rtl/kftvga_pkg.sv
// kftvga_pkg: shared VRAM arbiter FSM state type and default VRAM size
package kftvga_pkg;
  localparam int VRAM_SIZE_DEFAULT = 9600;
  typedef enum logic [2:0] {
    IDLE, V_LO, V_HI, V_CAP, CPU_RD, CPU_CAP, CPU_WR, CPU_DONE
  } state_t;
endpackage

// File: rtl/kftvga_vram_arbiter_if.sv
// kftvga_vram_arbiter_if: CPU request/response, video fetch and external RAM signals; slave = arbiter side, master = CPU/video/RAM side
interface kftvga_vram_arbiter_if;
  logic [13:0] cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [7:0]  cpu_data_in;
  logic [7:0]  cpu_data_out;
  logic        cpu_ready;
  logic        video_request;
  logic [12:0] video_address;
  logic [15:0] video_data_out;
  logic        video_data_valid;
  logic        video_overrun;
  logic [13:0] ram_address;
  logic        ram_write;
  logic [7:0]  ram_data_out;
  logic [7:0]  ram_data_in;
  modport slave (
    input  cpu_address, cpu_read, cpu_write, cpu_data_in, video_request, video_address, ram_data_in,
    output cpu_data_out, cpu_ready, video_data_out, video_data_valid, video_overrun,
    output ram_address, ram_write, ram_data_out
  );
  modport master (
    output cpu_address, cpu_read, cpu_write, cpu_data_in, video_request, video_address, ram_data_in,
    input  cpu_data_out, cpu_ready, video_data_out, video_data_valid, video_overrun,
    input  ram_address, ram_write, ram_data_out
  );
endinterface

// File: rtl/kftvga_vram_arbiter.sv
// kftvga_vram_arbiter: shares one single-port VRAM between CPU byte accesses and two-byte video cell fetches (video has priority); ports clock, reset, bus (slave)
module kftvga_vram_arbiter
  import kftvga_pkg::*;
#(
  parameter int VRAM_SIZE = VRAM_SIZE_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  kftvga_vram_arbiter_if.slave bus
);
  state_t      state_q, state_d;
  logic        pend;
  logic [12:0] pa, fa;
  logic [13:0] ca;
  logic [7:0]  cd, lo;
  logic        video_go, cpu_go, in_range;
  assign video_go = state_q == IDLE && (pend || bus.video_request);
  assign cpu_go   = state_q == IDLE && !video_go && (bus.cpu_read || bus.cpu_write);
  assign in_range = {18'd0, ca} < 32'(VRAM_SIZE);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q              <= IDLE;
      pend                 <= 1'b0;
      pa                   <= '0;
      fa                   <= '0;
      ca                   <= '0;
      cd                   <= '0;
      lo                   <= '0;
      bus.cpu_data_out     <= '0;
      bus.video_data_out   <= '0;
      bus.video_data_valid <= 1'b0;
      bus.video_overrun    <= 1'b0;
    end else begin
      state_q              <= state_d;
      bus.video_data_valid <= state_q == V_CAP;
      if (video_go) begin
        pend <= 1'b0;
        fa   <= bus.video_request ? bus.video_address : pa;
      end else if (bus.video_request) begin
        pend <= 1'b1;
        pa   <= bus.video_address;
      end
      if (bus.video_request && pend) bus.video_overrun <= 1'b1;
      if (cpu_go) begin
        ca <= bus.cpu_address;
        cd <= bus.cpu_data_in;
      end
      if (state_q == V_HI) lo <= bus.ram_data_in;
      if (state_q == V_CAP) bus.video_data_out <= {bus.ram_data_in, lo};
      if (state_q == CPU_CAP) bus.cpu_data_out <= in_range ? bus.ram_data_in : 8'h00;
    end
  end
  always_comb begin
    state_d          = state_q;
    bus.ram_address  = '0;
    bus.ram_write    = 1'b0;
    bus.ram_data_out = '0;
    bus.cpu_ready    = 1'b0;
    case (state_q)
      IDLE:     state_d = video_go ? V_LO : bus.cpu_write ? CPU_WR : bus.cpu_read ? CPU_RD : IDLE;
      V_LO: begin
        bus.ram_address = {fa, 1'b0};
        state_d         = V_HI;
      end
      V_HI: begin
        bus.ram_address = {fa, 1'b1};
        state_d         = V_CAP;
      end
      V_CAP:    state_d = IDLE;
      CPU_RD: begin
        bus.ram_address = ca;
        state_d         = CPU_CAP;
      end
      CPU_CAP: begin
        bus.ram_address = ca;
        state_d         = CPU_DONE;
      end
      CPU_WR: begin
        bus.ram_address  = ca;
        bus.ram_write    = in_range;
        bus.ram_data_out = cd;
        state_d          = CPU_DONE;
      end
      CPU_DONE: begin
        bus.cpu_ready = 1'b1;
        state_d       = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_kftvga_vram_arbiter.sv
// tb_kftvga_vram_arbiter: directed scoreboard bench for the VRAM arbiter with a behavioural single-port RAM
module tb_kftvga_vram_arbiter;
  typedef struct {
    int          cyc;
    logic [15:0] data;
    bit          chk;
  } exp_t;
  logic clk, rst;
  int   cyc, ncmp, nfail, bad_wr;
  exp_t cq[$], vq[$];
  logic [7:0] mem [0:16383];
  logic [7:0] ram_rd;
  kftvga_vram_arbiter_if bus();
  kftvga_vram_arbiter dut (.clock(clk), .reset(rst), .bus(bus.slave));
  assign bus.ram_data_in = ram_rd;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (bus.ram_write) mem[bus.ram_address] <= bus.ram_data_out;
    ram_rd <= mem[bus.ram_address];
  end
  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (bus.ram_write && bus.ram_address >= 14'd9600) bad_wr++;
    if (bus.cpu_ready) begin
      if (cq.size() == 0) chk("unexpected_cpu_ready", 1, 0);
      else begin
        e = cq.pop_front();
        chk("cpu_ready_cycle", cyc, e.cyc);
        if (e.chk) chk("cpu_data_out", int'(bus.cpu_data_out), int'(e.data));
      end
    end
    if (bus.video_data_valid) begin
      if (vq.size() == 0) chk("unexpected_video_valid", 1, 0);
      else begin
        e = vq.pop_front();
        chk("video_valid_cycle", cyc, e.cyc);
        chk("video_data_out", int'(bus.video_data_out), int'(e.data));
      end
    end
  end
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic cpu(input bit wr, input logic [13:0] a, input logic [7:0] d, input int lat, input logic [7:0] rd);
    bit got;
    bus.cpu_address = a;
    bus.cpu_data_in = d;
    bus.cpu_write   = wr;
    bus.cpu_read    = !wr;
    cq.push_back('{cyc + lat, {8'h00, rd}, !wr});
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.cpu_ready) got = 1;
    end
    if (!got) chk("cpu_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
  endtask
  task automatic vid(input logic [12:0] a, input bit push, input logic [15:0] d);
    bus.video_request = 1'b1;
    bus.video_address = a;
    if (push) vq.push_back('{cyc + 4, d, 1'b1});
    @(posedge clk);
    #1;
    bus.video_request = 1'b0;
  endtask
  initial begin
    ncmp = 0; nfail = 0; bad_wr = 0; cyc = 0;
    rst = 1'b1;
    bus.cpu_address = '0; bus.cpu_read = 1'b0; bus.cpu_write = 1'b0; bus.cpu_data_in = '0;
    bus.video_request = 1'b0; bus.video_address = '0;
    for (int i = 0; i < 16384; i++) mem[i] <= 8'h00;
    mem[16'h0010] <= 8'h41; mem[16'h0011] <= 8'h1F;
    mem[16'h000C] <= 8'h34; mem[16'h000D] <= 8'h12;
    mem[16'h000A] <= 8'hEE; mem[16'h000B] <= 8'hDD;
    mem[9600]     <= 8'h77;
    idle(2);
    chk("rst_cpu_ready", int'(bus.cpu_ready), 0);
    chk("rst_cpu_data_out", int'(bus.cpu_data_out), 0);
    chk("rst_video_valid", int'(bus.video_data_valid), 0);
    chk("rst_video_data", int'(bus.video_data_out), 0);
    chk("rst_overrun", int'(bus.video_overrun), 0);
    chk("rst_ram_address", int'(bus.ram_address), 0);
    chk("rst_ram_write", int'(bus.ram_write), 0);
    chk("rst_ram_data_out", int'(bus.ram_data_out), 0);
    rst = 1'b0;
    idle(2);
    vid(13'h008, 1, 16'h1F41);
    idle(6);
    cpu(1, 14'h0123, 8'hA5, 2, 8'h00);
    idle(1);
    cpu(0, 14'h0123, 8'h00, 3, 8'hA5);
    idle(2);
    vq.push_back('{cyc + 4, 16'h1F41, 1'b1});
    fork
      begin
        bus.video_request = 1'b1;
        bus.video_address = 13'h008;
        @(posedge clk);
        #1;
        bus.video_request = 1'b0;
      end
      cpu(0, 14'h0123, 8'h00, 7, 8'hA5);
    join
    idle(3);
    chk("overrun_before", int'(bus.video_overrun), 0);
    bus.cpu_address = 14'h0123;
    bus.cpu_read    = 1'b1;
    cq.push_back('{cyc + 3, 16'h00A5, 1'b1});
    idle(1);
    bus.video_request = 1'b1;
    bus.video_address = 13'h005;
    idle(1);
    bus.video_address = 13'h006;
    vq.push_back('{cyc + 6, 16'h1234, 1'b1});
    idle(1);
    bus.video_request = 1'b0;
    idle(1);
    bus.cpu_read = 1'b0;
    idle(8);
    chk("overrun_after", int'(bus.video_overrun), 1);
    cpu(1, 14'd9600, 8'h55, 2, 8'h00);
    idle(1);
    cpu(0, 14'd9600, 8'h00, 3, 8'h00);
    idle(1);
    cpu(1, 14'd9599, 8'h66, 2, 8'h00);
    idle(1);
    cpu(0, 14'd9599, 8'h00, 3, 8'h66);
    idle(2);
    vid(13'h005, 0, 16'h0000);
    idle(1);
    rst = 1'b1;
    #1;
    chk("midrst_video_data", int'(bus.video_data_out), 0);
    chk("midrst_video_valid", int'(bus.video_data_valid), 0);
    chk("midrst_overrun", int'(bus.video_overrun), 0);
    chk("midrst_ram_address", int'(bus.ram_address), 0);
    chk("midrst_cpu_data_out", int'(bus.cpu_data_out), 0);
    chk("midrst_cpu_ready", int'(bus.cpu_ready), 0);
    idle(1);
    rst = 1'b0;
    idle(8);
    chk("oob_ram_writes", bad_wr, 0);
    chk("mem_9600_untouched", int'(mem[9600]), 8'h77);
    chk("cpu_queue_drained", cq.size(), 0);
    chk("video_queue_drained", vq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
